// File: rtl/div_32x16_signed_seq_pkg.sv
// Shared widths, iteration count and FSM encoding for the sequential 32/16 divider.
package div_32x16_signed_seq_pkg;

  localparam int unsigned WidthN   = 32;
  localparam int unsigned WidthD   = 16;
  localparam int unsigned DivSteps = WidthN;
  localparam int unsigned CntW     = $clog2(WidthN);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } state_e;

endpackage

// File: rtl/div_32x16_signed_seq_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface div_32x16_signed_seq_if;
  import div_32x16_signed_seq_pkg::*;

  logic              start;
  logic [WidthN-1:0] dividend;
  logic [WidthD-1:0] divisor;
  logic              busy;
  logic              done;
  logic [WidthN-1:0] quotient;
  logic [WidthD-1:0] remainder;
  logic              div_by_zero;
  logic              overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_32x16_signed_seq_step.sv
// One restoring-division step on magnitudes: shift {rem,quo} left, subtract if it fits.
module div_32x16_signed_seq_step
  import div_32x16_signed_seq_pkg::*;
(
  input  logic [WidthD-1:0] rem_i,
  input  logic [WidthN-1:0] quo_i,
  input  logic [WidthD-1:0] dvs_i,
  output logic [WidthD-1:0] rem_o,
  output logic [WidthN-1:0] quo_o
);

  logic [WidthD:0]   shifted;
  logic [WidthD-1:0] diff;
  logic              fits;

  always_comb begin
    shifted = {rem_i, quo_i[WidthN-1]};
    fits    = (shifted >= {1'b0, dvs_i});
    // When the trial fits the result is below the divisor, so 16 bits suffice.
    diff    = shifted[WidthD-1:0] - dvs_i;
    rem_o   = fits ? diff : shifted[WidthD-1:0];
    quo_o   = {quo_i[WidthN-2:0], fits};
  end

endmodule

// File: rtl/div_32x16_signed_seq.sv
// Sequential restoring 32/16 divider, fixed 34-cycle latency, optional two's complement mode.
module div_32x16_signed_seq
  import div_32x16_signed_seq_pkg::*;
#(
  parameter bit IsSigned = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   sclr_i,
  div_32x16_signed_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [WidthN-1:0] quo_q, quo_step, fix_quo, quo_out_q;
  logic [WidthD-1:0] rem_q, rem_step, fix_rem, dbz_rem, rem_out_q;
  logic [WidthD-1:0] dvs_q;
  logic              sign_n_q, sign_d_q, dbz_q, ovf_q;
  logic              done_q, dbz_out_q, ovf_out_q;
  logic              n_neg, d_neg;
  logic [WidthN-1:0] mag_n;
  logic [WidthD-1:0] mag_d;

  div_32x16_signed_seq_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_ff @(posedge clk_i) begin
    if (sclr_i) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = (bus.divisor == '0) ? StFix : StCalc;
      StCalc:  if (cnt_q == CntW'(DivSteps - 1)) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q != StIdle);
    bus.done        = done_q;
    bus.quotient    = quo_out_q;
    bus.remainder   = rem_out_q;
    bus.div_by_zero = dbz_out_q;
    bus.overflow    = ovf_out_q;
  end

  always_comb begin
    n_neg   = IsSigned && bus.dividend[WidthN-1];
    d_neg   = IsSigned && bus.divisor[WidthD-1];
    mag_n   = n_neg ? -bus.dividend : bus.dividend;
    mag_d   = d_neg ? -bus.divisor : bus.divisor;
    fix_quo = (sign_n_q ^ sign_d_q) ? -quo_q : quo_q;
    fix_rem = sign_n_q ? -rem_q : rem_q;
    // On divide-by-zero quo_q still holds |dividend|; re-sign it to recover the raw low half.
    dbz_rem = sign_n_q ? -quo_q[WidthD-1:0] : quo_q[WidthD-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (sclr_i) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      sign_n_q  <= 1'b0;
      sign_d_q  <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            quo_q     <= mag_n;
            rem_q     <= '0;
            dvs_q     <= mag_d;
            sign_n_q  <= n_neg;
            sign_d_q  <= d_neg;
            cnt_q     <= '0;
            dbz_q     <= (bus.divisor == '0);
            ovf_q     <= IsSigned && (bus.dividend == 32'h8000_0000) &&
                         (bus.divisor == 16'hFFFF);
            dbz_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
          end
        end
        StCalc: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + 1'b1;
        end
        StFix: begin
          done_q    <= 1'b1;
          quo_out_q <= dbz_q ? '1 : fix_quo;
          rem_out_q <= dbz_q ? dbz_rem : fix_rem;
          dbz_out_q <= dbz_q;
          ovf_out_q <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32x16_signed_seq.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop and compare on Done.
module tb_div_32x16_signed_seq;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] n;
    logic [15:0] d;
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic sclr = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sq[$];
  exp_t uq[$];

  div_32x16_signed_seq_if bus ();
  div_32x16_signed_seq_if ubus ();

  div_32x16_signed_seq #(.IsSigned(1'b1)) dut (
    .clk_i  (clk),
    .sclr_i (sclr),
    .bus    (bus)
  );

  div_32x16_signed_seq #(.IsSigned(1'b0)) dut_u (
    .clk_i  (clk),
    .sclr_i (sclr),
    .bus    (ubus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sq.size() == 0) begin
        chk("signed_unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = sq.pop_front();
        chk("signed_quotient",  64'(bus.quotient),    64'(e.q));
        chk("signed_remainder", 64'(bus.remainder),   64'(e.r));
        chk("signed_divbyzero", 64'(bus.div_by_zero), 64'(e.dbz));
        chk("signed_overflow",  64'(bus.overflow),    64'(e.ovf));
        chk("signed_done_cycle", 64'(cyc),            64'(e.cyc));
        chk("signed_busy_at_done", 64'(bus.busy),     64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (ubus.done) begin
      if (uq.size() == 0) begin
        chk("unsigned_unexpected_done", 64'(ubus.done), 64'd0);
      end else begin
        exp_t e;
        e = uq.pop_front();
        chk("unsigned_quotient",  64'(ubus.quotient),  64'(e.q));
        chk("unsigned_remainder", 64'(ubus.remainder), 64'(e.r));
        chk("unsigned_overflow",  64'(ubus.overflow),  64'(e.ovf));
        chk("unsigned_done_cycle", 64'(cyc),           64'(e.cyc));
      end
    end
  end

  // Call right after a negedge; returns one negedge later with Start dropped.
  task automatic issue(input vec_t v);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = v.n;
    bus.divisor  = v.d;
    e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.ovf = v.ovf;
    e.cyc = cyc + (v.dbz ? 2 : 34);
    sq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && sq.size() != 0; i++) @(negedge clk);
    chk(name, 64'(sq.size()), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy),        64'd0);
    chk({tag, "_done"}, 64'(bus.done),        64'd0);
    chk({tag, "_q"},    64'(bus.quotient),    64'd0);
    chk({tag, "_r"},    64'(bus.remainder),   64'd0);
    chk({tag, "_dbz"},  64'(bus.div_by_zero), 64'd0);
    chk({tag, "_ovf"},  64'(bus.overflow),    64'd0);
  endtask

  vec_t vecs[9] = '{
    '{32'd1000,      16'd7,      32'd142,       16'd6,      1'b0, 1'b0},
    '{32'hFFFFFC18,  16'd7,      32'hFFFFFF72,  16'hFFFA,   1'b0, 1'b0},
    '{32'd1000,      16'hFFF9,   32'hFFFFFF72,  16'd6,      1'b0, 1'b0},
    '{32'h80000000,  16'hFFFF,   32'h80000000,  16'd0,      1'b0, 1'b1},
    '{32'h12345678,  16'd0,      32'hFFFFFFFF,  16'h5678,   1'b1, 1'b0},
    '{32'hFFFFFFFE,  16'd0,      32'hFFFFFFFF,  16'hFFFE,   1'b1, 1'b0},
    '{32'hFFFFFFF9,  16'd2,      32'hFFFFFFFD,  16'hFFFF,   1'b0, 1'b0},
    '{32'h00010000,  16'h8000,   32'hFFFFFFFE,  16'd0,      1'b0, 1'b0},
    '{32'h80000000,  16'h8000,   32'h00010000,  16'd0,      1'b0, 1'b0}
  };

  vec_t uvecs[2] = '{
    '{32'hFFFFFFFF,  16'hFFFF,   32'h00010001,  16'd0,      1'b0, 1'b0},
    '{32'h80000000,  16'd2,      32'h40000000,  16'd0,      1'b0, 1'b0}
  };

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    ubus.start = 1'b0; ubus.dividend = '0; ubus.divisor = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    sclr = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i]);
      drain("vector_completed");
    end

    // Start pulses while busy must be ignored.
    issue('{32'd500, 16'd5, 32'd100, 16'd0, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
    end
    drain("busy_ignore_completed");

    // Back-to-back: Start held high through the first job into its Done cycle.
    begin
      exp_t e1, e2;
      int   c;
      c = cyc;
      e1.q = 32'd33; e1.r = 16'd1; e1.dbz = 1'b0; e1.ovf = 1'b0; e1.cyc = c + 34;
      e2.q = 32'd3;  e2.r = 16'd1; e2.dbz = 1'b0; e2.ovf = 1'b0; e2.cyc = c + 68;
      sq.push_back(e1);
      sq.push_back(e2);
      bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd3;
      @(negedge clk);
      bus.dividend = 32'd7; bus.divisor = 16'd2;
      for (int i = 0; i < 60 && !bus.done; i++) @(negedge clk);
      chk("b2b_first_done_seen", 64'(bus.done), 64'd1);
      @(negedge clk);
      bus.start = 1'b0;
      drain("b2b_completed");
    end

    // Sclr mid-calculation aborts the job with no Done.
    bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    chk_zero_outputs("abort");
    repeat (45) @(negedge clk);
    issue('{32'd77, 16'd7, 32'd11, 16'd0, 1'b0, 1'b0});
    drain("after_abort_completed");

    foreach (uvecs[i]) begin
      exp_t e;
      ubus.start = 1'b1; ubus.dividend = uvecs[i].n; ubus.divisor = uvecs[i].d;
      e.q = uvecs[i].q; e.r = uvecs[i].r; e.dbz = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 34;
      uq.push_back(e);
      @(negedge clk);
      ubus.start = 1'b0;
      for (int k = 0; k < 80 && uq.size() != 0; k++) @(negedge clk);
      chk("unsigned_completed", 64'(uq.size()), 64'd0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
